wb_arbiter_2m: RTL
==================

Name: wb_arbiter_2m

Overview:
Two-master, one-slave pipelined Wishbone (B4, with STALL) arbiter. It shares the single Wishbone port between the Ibex instruction-side and data-side bridges, placing one Wishbone-to-core bridge upstream of each master port.
- Round-robin arbitration, locked for the whole CYC burst.
- Per-grant outstanding-transfer tracking.
- Bus-timeout watchdog returning ERR to a hung master.

Parameters:
ADR_W, 28, address width (word address)
DAT_W, 32, data width
SEL_W, 4, byte-select width (DAT_W/8)
MAX_OUTSTANDING, 4, max accepted-but-unacknowledged strobes per grant
TIMEOUT_CYCLES, 1024, watchdog limit; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
m0_cyc_i / m1_cyc_i  in  1  master CYC
m0_stb_i / m1_stb_i  in  1  master STB
m0_we_i / m1_we_i  in  1  master WE
m0_adr_i / m1_adr_i  in  ADR_W  master address
m0_sel_i / m1_sel_i  in  SEL_W  master byte select
m0_dat_i / m1_dat_i  in  DAT_W  master write data
m0_ack_o / m1_ack_o  out  1  ACK to master
m0_err_o / m1_err_o  out  1  ERR to master
m0_stall_o / m1_stall_o  out  1  STALL to master
m0_dat_o / m1_dat_o  out  DAT_W  read data (slave data broadcast)
s_cyc_o, s_stb_o, s_we_o  out  1  slave strobes
s_adr_o  out  ADR_W  slave address
s_sel_o  out  SEL_W  slave byte select
s_dat_o  out  DAT_W  slave write data
s_ack_i, s_err_i, s_stall_i  in  1  slave responses
s_dat_i  in  DAT_W  slave read data

Behaviour:
- Reset state (asynchronous assert, synchronous release):
  - state=IDLE, last_grant=1 (M0 wins first contention).
  - outstanding=0, wdog=0.
  - All s_* outputs 0; all m*_ack/err 0; m*_stall 1.
- States:
  - IDLE: no grant.
  - GNT0 / GNT1: M0 / M1 owns the bus.
- IDLE transitions, evaluated on registered decision at the clock edge:
  - m0_cyc only -> GNT0.
  - m1_cyc only -> GNT1.
  - Both -> the master != last_grant.
- Arbitration latency is 1 cycle. A master is never granted combinationally in IDLE.
- GNTx muxing:
  - s_cyc_o = mx_cyc_i; s_stb/we/adr/sel/dat = master x inputs.
  - mx_ack_o = s_ack_i (gated, see stray acks); mx_err_o = s_err_i or watchdog error.
  - mx_stall_o = s_stall_i OR (outstanding==MAX_OUTSTANDING).
  - When outstanding==MAX_OUTSTANDING, s_stb_o is forced 0.
- Non-granted master: ack=0, err=0, stall=1.
- m*_dat_o = s_dat_i always.
- In IDLE all s_* outputs are driven 0.
- outstanding:
  - +1 on s_stb_o & !s_stall_i; -1 on (s_ack_i|s_err_i).
  - Both in the same cycle -> unchanged.
  - Width is clog2(MAX_OUTSTANDING+1).
- Stray ack/err (arrives with outstanding==0) is dropped, not forwarded.
- Release: on the edge where mx_cyc_i==0 in GNTx:
  - last_grant <= x; outstanding <= 0; wdog <= 0.
  - Next state = GNTy if my_cyc_i==1, else IDLE. Handover is direct, with no idle bubble.
- CYC dropped with outstanding>0 is a master abort: the counter clears and later responses are dropped.
- Watchdog (TIMEOUT_CYCLES>0):
  - wdog increments each granted cycle with outstanding>0 and no s_ack/s_err; it clears on any response or release.
  - When wdog==TIMEOUT_CYCLES-1 and no response that cycle:
    - mx_err_o=1 for that cycle.
    - s_cyc_o forced 0 that cycle (slave abort).
    - outstanding <= 0, wdog <= 0. The grant is retained until the master drops CYC.
- Simultaneous release of master x and new request from x: x loses to y if y requests; otherwise x is regranted after passing through IDLE.
- Reset mid-transfer: everything returns to reset values immediately and the slave cyc drops asynchronously.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum arb_state_t {IDLE,GNT0,GNT1}.
  - Default width localparams WB_ADR_W=28, WB_DAT_W=32, WB_SEL_W=4.
- Natural sub-module: wb_xfer_tracker, containing:
  - the outstanding counter;
  - the stall-at-limit flag;
  - the stray-response filter;
  - the watchdog;
  - inputs stb/stall/ack/err/clear; outputs outstanding_full, resp_valid, timeout_err.
- The top holds the FSM and the muxes.

Test Plan:
- After reset, M0 read (adr=0x0000010, sel=4'hF), slave ack 2 cycles after the strobe:
  - s_cyc rises 1 cycle after m0_cyc.
  - m0_ack pulses once; m1_stall stays 1.
  - State returns to IDLE the cycle after m0_cyc falls.
- M0 and M1 assert cyc on the same cycle, three times in succession, each burst with 1 write:
  - Grants alternate M0, M1, M0.
  - Each handover has no IDLE cycle when the other master is still waiting.
- M1 issues 6 back-to-back strobes and the slave withholds acks:
  - s_stb accepted 4 times; m1_stall=1 from the 5th onward.
  - Stall releases one cycle after the first ack.
- Slave stall=1 for 3 cycles on an M0 write with dat=0xDEADBEEF:
  - s_adr/s_dat stay stable; m0_stall=1 for exactly 3 cycles.
  - Exactly one increment of outstanding.
- TIMEOUT_CYCLES=8, slave never acks:
  - m0_err pulses 8 cycles after the accepted strobe; s_cyc low for that cycle.
  - A late s_ack_i is not forwarded to m0_ack_o.
- rst asserted mid-burst with outstanding=2:
  - s_cyc_o=0 and both m*_stall=1 within the same cycle, without a clock edge.
  - After release, the first contention is won by M0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared state encoding and default bus widths for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int unsigned WB_ADR_W = 28;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

endpackage

// File: rtl/wb_arbiter_2m_tracker.sv
// Per-grant transfer bookkeeping: outstanding strobe count, stray-response
// filter and bus-timeout watchdog for the currently granted master.
module wb_xfer_tracker
  import wb_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic stb_i,
  input  logic stall_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic clear_i,
  output logic outstanding_full_o,
  output logic resp_valid_o,
  output logic timeout_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic        WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             resp, has_out, accept;

  // Outputs kept apart from next-state so stb_i (derived from them) forms no loop.
  always_comb begin
    resp               = ack_i | err_i;
    has_out            = (outstanding_q != '0);
    outstanding_full_o = (outstanding_q == CNT_MAX);
    resp_valid_o       = active_i & resp & has_out;
    timeout_err_o      = WD_EN & active_i & ~clear_i & has_out & ~resp & (wdog_q == WD_LAST);
  end

  always_comb begin
    outstanding_d = outstanding_q;
    wdog_d        = wdog_q;
    accept        = stb_i & ~stall_i & ~outstanding_full_o;
    if (clear_i || timeout_err_o) begin
      outstanding_d = '0;
      wdog_d        = '0;
    end else begin
      if (accept && !resp_valid_o) begin
        outstanding_d = outstanding_q + CNT_W'(1);
      end else if (!accept && resp_valid_o) begin
        outstanding_d = outstanding_q - CNT_W'(1);
      end
      if (resp) begin
        wdog_d = '0;
      end else if (WD_EN && has_out) begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      wdog_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      wdog_q        <= wdog_d;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave pipelined Wishbone B4 arbiter: round-robin grant held
// for the whole CYC burst, with outstanding-limit stall and timeout abort.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADR_W           = WB_ADR_W,
  parameter int unsigned DAT_W           = WB_DAT_W,
  parameter int unsigned SEL_W           = WB_SEL_W,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic             m0_stall_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             m1_stall_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_stall_i,
  input  logic [DAT_W-1:0] s_dat_i
);

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt0, gnt1, granted;
  logic             x_cyc, x_stb, x_we;
  logic [ADR_W-1:0] x_adr;
  logic [SEL_W-1:0] x_sel;
  logic [DAT_W-1:0] x_dat;
  logic             trk_clear, full, resp_valid, timeout_err;
  logic             ack_x, err_x, stall_x;

  always_comb begin
    gnt0      = (state_q == GNT0);
    gnt1      = (state_q == GNT1);
    granted   = gnt0 | gnt1;
    x_cyc     = gnt1 ? m1_cyc_i : m0_cyc_i;
    x_stb     = gnt1 ? m1_stb_i : m0_stb_i;
    x_we      = gnt1 ? m1_we_i  : m0_we_i;
    x_adr     = gnt1 ? m1_adr_i : m0_adr_i;
    x_sel     = gnt1 ? m1_sel_i : m0_sel_i;
    x_dat     = gnt1 ? m1_dat_i : m0_dat_i;
    trk_clear = ~granted | ~x_cyc;
  end

  wb_xfer_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_tracker (
    .clk                (clk),
    .rst                (rst),
    .active_i           (granted),
    .stb_i              (s_stb_o),
    .stall_i            (s_stall_i),
    .ack_i              (s_ack_i),
    .err_i              (s_err_i),
    .clear_i            (trk_clear),
    .outstanding_full_o (full),
    .resp_valid_o       (resp_valid),
    .timeout_err_o      (timeout_err)
  );

  // A watchdog abort drops slave CYC for one cycle and stalls the owner so no strobe is lost.
  always_comb begin
    s_cyc_o    = granted & x_cyc & ~timeout_err;
    s_stb_o    = s_cyc_o & x_stb & ~full;
    s_we_o     = granted & x_we;
    s_adr_o    = granted ? x_adr : '0;
    s_sel_o    = granted ? x_sel : '0;
    s_dat_o    = granted ? x_dat : '0;
    ack_x      = resp_valid & s_ack_i;
    err_x      = (resp_valid & s_err_i) | timeout_err;
    stall_x    = s_stall_i | full | timeout_err;
    m0_ack_o   = gnt0 & ack_x;
    m0_err_o   = gnt0 & err_x;
    m0_stall_o = ~gnt0 | stall_x;
    m1_ack_o   = gnt1 & ack_x;
    m1_err_o   = gnt1 & err_x;
    m1_stall_o = ~gnt1 | stall_x;
    m0_dat_o   = s_dat_i;
    m1_dat_o   = s_dat_i;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_grant_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_grant_d = 1'b0;
          state_d      = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_grant_d = 1'b1;
          state_d      = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
